// File: rtl/data_bus_pkg.sv
// Shared constants for the two-master data bus arbiter.
package data_bus_pkg;

  localparam int DBUS_AW = 8;
  localparam int DBUS_DW = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

endpackage

// File: rtl/bus_watchdog.sv
// Ack watchdog: counts stalled strobe cycles of the current owner and
// raises a single-cycle err pulse once TIMEOUT cycles pass without ack.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic granted,
  input  logic owner_stb,
  input  logic ack,
  output logic err_cycle
);

  localparam logic [7:0] WD_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  logic [7:0] wd_cnt;

  // Timeout fires on the cycle that would be the TIMEOUT-th stall; ack wins a tie.
  always_comb begin
    err_cycle = (TIMEOUT > 0) && granted && owner_stb && !ack && (wd_cnt == WD_LAST);
  end

  // Stall counter; held at zero whenever the watchdog is disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt <= 8'd0;
    end else if (!granted || ack || !owner_stb || err_cycle || (TIMEOUT == 0)) begin
      wd_cnt <= 8'd0;
    end else begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master, one-slave Wishbone-classic arbiter for the data memory bus.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no owner; slave side driven to zero
// GNT0    | master 0 owns the slave until it drops cyc
// GNT1    | master 1 owns the slave until it drops cyc
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [DBUS_AW-1:0] m0_adr_i,
  input  logic [DBUS_DW-1:0] m0_dat_i,
  output logic [DBUS_DW-1:0] m0_dat_o,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [DBUS_AW-1:0] m1_adr_i,
  input  logic [DBUS_DW-1:0] m1_dat_i,
  output logic [DBUS_DW-1:0] m1_dat_o,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [DBUS_AW-1:0] s_adr_o,
  output logic [DBUS_DW-1:0] s_dat_o,
  input  logic [DBUS_DW-1:0] s_dat_i,
  input  logic               s_ack_i,
  output logic [1:0]         gnt_o
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_owner;
  logic       last_owner_nxt;
  logic       gnt0;
  logic       gnt1;
  logic       owner_stb;
  logic       err_cycle;

  // Grant decision: ties from IDLE go to the master that did not own last.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = ((ROUND_ROBIN != 0) && (last_owner == 1'b0)) ? ST_GNT1 : ST_GNT0;
        end else if (m0_cyc_i) begin
          state_nxt = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          last_owner_nxt = 1'b0;
          state_nxt      = m1_cyc_i ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          last_owner_nxt = 1'b1;
          state_nxt      = m0_cyc_i ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant state and round-robin history; last_owner starts at 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  assign gnt0  = (state == ST_GNT0);
  assign gnt1  = (state == ST_GNT1);
  assign gnt_o = {gnt1, gnt0};

  // Slave-side mux; strobe is withheld on the timeout cycle so the slave sees no access.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    owner_stb = 1'b0;
    if (gnt0) begin
      s_cyc_o   = m0_cyc_i;
      s_stb_o   = m0_stb_i & ~err_cycle;
      s_we_o    = m0_we_i;
      s_adr_o   = m0_adr_i;
      s_dat_o   = m0_dat_i;
      owner_stb = m0_stb_i;
    end else if (gnt1) begin
      s_cyc_o   = m1_cyc_i;
      s_stb_o   = m1_stb_i & ~err_cycle;
      s_we_o    = m1_we_i;
      s_adr_o   = m1_adr_i;
      s_dat_o   = m1_dat_i;
      owner_stb = m1_stb_i;
    end
  end

  // Responses reach only the owner; an ack seen in IDLE is simply dropped.
  always_comb begin
    m0_ack_o = gnt0 & m0_stb_i & s_ack_i;
    m1_ack_o = gnt1 & m1_stb_i & s_ack_i;
    m0_err_o = gnt0 & err_cycle;
    m1_err_o = gnt1 & err_cycle;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
  end

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .granted  (gnt0 | gnt1),
    .owner_stb(owner_stb),
    .ack      (s_ack_i),
    .err_cycle(err_cycle)
  );

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the 8-bit Wishbone-classic data memory bus.
- Master 0 is the gumnut core data port. Master 1 is a secondary requester, such as a DMA or debug loader.
- The slave is data_mem.
- Round-robin grant, with hand-off on cyc release and a per-transfer ack watchdog that returns err to a stalled master.
- Sits between gumnut_with_mem's core data bus and core_data_mem.

Parameters:
- ROUND_ROBIN, 1: 1 selects round-robin; 0 selects fixed priority, with master 0 always winning ties.
- TIMEOUT, 16: cycles of stb-without-ack before err. 0 disables the watchdog. Legal range 0..255.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- m0_cyc_i  in  1  master 0 bus cycle request
- m0_stb_i  in  1  master 0 strobe
- m0_we_i  in  1  master 0 write enable
- m0_adr_i  in  8  master 0 address
- m0_dat_i  in  8  master 0 write data
- m0_dat_o  out  8  master 0 read data
- m0_ack_o  out  1  master 0 acknowledge
- m0_err_o  out  1  master 0 timeout error
- m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o: same as master 0, for master 1
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_adr_o  out  8  slave address
- s_dat_o  out  8  slave write data
- s_dat_i  in  8  slave read data
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot grant: bit0 = master 0, bit1 = master 1, 00 = idle

Behaviour:
- Reset (asynchronous on rst_ni=0):
  - state=IDLE, gnt_o=00, last_owner=1 (so master 0 wins the first tie), wd_cnt=0.
  - All s_* outputs and m*_ack/err are 0 through the combinational gating below.
- States are IDLE, GNT0, GNT1. Transitions are evaluated on each rising edge:
  - IDLE:
    - Only m0_cyc → GNT0; only m1_cyc → GNT1.
    - Both requesting → the master that is not last_owner, if ROUND_ROBIN=1; otherwise GNT0.
  - GNTn with mn_cyc=1: stay.
  - GNTn with mn_cyc=0:
    - The other master's cyc=1 → direct hand-off to that master's grant state, with no IDLE bubble.
    - Otherwise → IDLE.
    - last_owner←n in both cases.
- Grant latency: a request first sampled in IDLE at edge k is granted from cycle k+1; the slave sees stb no earlier than cycle k+1.
- A granted master is never preempted while its cyc is high, including multi-beat cycles (cyc held, stb toggling).
- Muxing (combinational from the state register):
  - In GNTn, the s_* outputs carry mn_* and s_stb_o = mn_stb_i & ~err_cycle.
  - In IDLE, s_cyc_o = s_stb_o = s_we_o = 0 and s_adr_o = s_dat_o = 0.
  - s_ack_i routes only to the granted master's ack, gated with its stb. The non-granted master's ack/err are always 0.
  - s_dat_i routes to both m*_dat_o unconditionally; masters qualify it with ack.
  - An ack arriving in IDLE is dropped.
- Watchdog, 8-bit wd_cnt:
  - Clears when not granted, on ack, on owner stb=0, or on err.
  - Increments each cycle the owner has stb=1 and ack=0.
  - When wd_cnt == TIMEOUT-1 and ack=0 (TIMEOUT>0):
    - err_cycle=1 for exactly one cycle: owner err_o=1, and s_stb_o is forced to 0 in that cycle.
    - The grant is kept; the master decides whether to drop cyc.
  - Ack and timeout in the same cycle: ack wins and err stays 0.
- Simultaneous owner release and other-master request: hand-off happens on that edge. last_owner updates on the same edge.
- Reset mid-transfer: grant drops at once (asynchronously), and a pending slave ack is discarded.

Decomposition:
- Shared package data_bus_pkg:
  - State encoding constants ST_IDLE, ST_GNT0, ST_GNT1.
  - Bus width constants DBUS_AW=8, DBUS_DW=8.
- One natural sub-module: bus_watchdog, which holds the counter, compare and err_cycle pulse. It is parameterised by TIMEOUT and instantiated once.
- The FSM and the muxes stay in the top level.

Test Plan:
- m0 single write (adr 0x10, dat 0xA5), slave acks one cycle after stb → s_* mirror m0 from the cycle after request; gnt_o=01; m0_ack_o pulses once; m1_ack_o stays 0; the read-back of 0x10 by m0 returns 0xA5.
- Both masters assert cyc in the same cycle, three times back-to-back, ROUND_ROBIN=1 → grants alternate 01, 10, 01. With ROUND_ROBIN=0 → 01 every time.
- m0 holds cyc over 4 stb beats while m1 requests → m1 is not granted until m0 drops cyc. gnt_o goes 01→10 on that edge with no 00 cycle.
- TIMEOUT=4, slave never acks m1 → m1_err_o=1 on the 4th stb cycle only; s_stb_o=0 in that cycle; gnt_o stays 10 until m1 drops cyc.
- Ack arrives on exactly the 4th cycle (TIMEOUT=4) → ack delivered, err=0, wd_cnt=0. With TIMEOUT=0, no err after 300 stalled cycles.
- rst_ni pulsed low asynchronously mid-transfer in GNT1 → gnt_o=00 and s_cyc_o=0 immediately. After release, a simultaneous request grants m0 first.
